// File: rtl/pulse_divider.sv
// pulse_divider: programmable divider that emits a registered one-cycle
// tick every N enabled clock cycles.
//
// A new divisor loaded mid-period is held pending and applied at the next
// terminal count, so the period in flight always completes. A load on a
// terminal-count edge, a paused edge, or while stopped is applied at once.
// A divisor of 0 stops the divider.
//
// Optional build macro SQUARE_OUT_EN adds oSquare, a 50% duty square wave
// with a period of 2N enabled cycles.
module pulse_divider #(
    parameter int WIDTH     = 26,
    parameter int DIV_RESET = 50_000_000
) (
    input  logic             iClk,
    input  logic             irst,
    input  logic             iEn,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iDiv,
    output logic             oPulse,
    output logic             oPending,
    output logic [WIDTH-1:0] oCount
`ifdef SQUARE_OUT_EN
    ,
    output logic             oSquare
`endif
);

    localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DIV_RESET);

    logic [WIDTH-1:0] rCnt;
    logic [WIDTH-1:0] rDiv;
    logic [WIDTH-1:0] rPend;
    logic             rPulse;
    logic             rPending;

    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] div_nxt;
    logic [WIDTH-1:0] pend_nxt;
    logic             pulse_nxt;
    logic             pending_nxt;

    logic             div_zero;
    logic             terminal;

`ifdef SQUARE_OUT_EN
    logic             rSquare;
    logic             square_nxt;
`endif

    // The counter never exceeds rDiv-1, so equality is a complete terminal test.
    assign div_zero = (rDiv == '0);
    assign terminal = (rCnt == rDiv - WIDTH'(1));

    // Next-state selection; priority is stopped, then paused, then terminal, then counting.
    always_comb begin
        cnt_nxt     = rCnt;
        div_nxt     = rDiv;
        pend_nxt    = rPend;
        pending_nxt = rPending;
        pulse_nxt   = 1'b0;
`ifdef SQUARE_OUT_EN
        square_nxt  = rSquare;
`endif
        if (div_zero) begin
            // Stopped: counter parked at zero; a load restarts it immediately.
            cnt_nxt = '0;
`ifdef SQUARE_OUT_EN
            square_nxt = 1'b0;
`endif
            if (iLoad) begin
                div_nxt     = iDiv;
                pending_nxt = 1'b0;
            end
        end else if (!iEn) begin
            // Paused: count held; a load applies now and restarts the period.
            if (iLoad) begin
                div_nxt     = iDiv;
                cnt_nxt     = '0;
                pending_nxt = 1'b0;
            end
        end else if (terminal) begin
            cnt_nxt   = '0;
            pulse_nxt = 1'b1;
`ifdef SQUARE_OUT_EN
            square_nxt = ~rSquare;
`endif
            // A fresh load takes priority over an older pending value.
            if (iLoad) begin
                div_nxt     = iDiv;
                pending_nxt = 1'b0;
            end else if (rPending) begin
                div_nxt     = rPend;
                pending_nxt = 1'b0;
            end
        end else begin
            cnt_nxt = rCnt + WIDTH'(1);
            // Mid-period load: park it until the period ends; last load wins.
            if (iLoad) begin
                pend_nxt    = iDiv;
                pending_nxt = 1'b1;
            end
        end
    end

    // State register with synchronous reset overriding every other input.
    always_ff @(posedge iClk) begin
        if (irst) begin
            rCnt     <= '0;
            rDiv     <= DIV_INIT;
            rPend    <= '0;
            rPulse   <= 1'b0;
            rPending <= 1'b0;
        end else begin
            rCnt     <= cnt_nxt;
            rDiv     <= div_nxt;
            rPend    <= pend_nxt;
            rPulse   <= pulse_nxt;
            rPending <= pending_nxt;
        end
    end

`ifdef SQUARE_OUT_EN
    // Square-wave register: toggles on terminal counts, cleared by reset.
    always_ff @(posedge iClk) begin
        if (irst) begin
            rSquare <= 1'b0;
        end else begin
            rSquare <= square_nxt;
        end
    end

    assign oSquare = rSquare;
`endif

    assign oCount   = rCnt;
    assign oPulse   = rPulse;
    assign oPending = rPending;

endmodule

// File: tb/tb_pulse_divider.sv
// tb_pulse_divider: directed scenarios plus a randomized run for
// pulse_divider (WIDTH=8, DIV_RESET=5), checked against a behavioural
// model. Build with +define+SQUARE_OUT_EN to include the square output.
module tb_pulse_divider;

    localparam int WIDTH     = 8;
    localparam int DIV_RESET = 5;

    logic             iClk;
    logic             irst;
    logic             iEn;
    logic             iLoad;
    logic [WIDTH-1:0] iDiv;
    logic             oPulse;
    logic             oPending;
    logic [WIDTH-1:0] oCount;
`ifdef SQUARE_OUT_EN
    logic             oSquare;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: divisor, parked divisor, phase within period.
    int m_div;
    int m_pend;
    int m_phase;
    bit m_pending;
    bit m_pulse;
    bit m_square;

    pulse_divider #(
        .WIDTH     (WIDTH),
        .DIV_RESET (DIV_RESET)
    ) dut (
        .iClk     (iClk),
        .irst     (irst),
        .iEn      (iEn),
        .iLoad    (iLoad),
        .iDiv     (iDiv),
        .oPulse   (oPulse),
        .oPending (oPending),
        .oCount   (oCount)
`ifdef SQUARE_OUT_EN
        ,
        .oSquare  (oSquare)
`endif
    );

    // Clock: 10 time-unit period.
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference behaviour, phrased as period arithmetic.
    task automatic model_edge(input bit rst, input bit en, input bit ld, input int div);
        m_pulse = 1'b0;
        if (rst) begin
            m_div = DIV_RESET; m_pend = 0; m_phase = 0;
            m_pending = 1'b0; m_square = 1'b0;
        end else if (m_div == 0) begin
            m_phase = 0; m_square = 1'b0;
            if (ld) begin m_div = div; m_pending = 1'b0; end
        end else if (!en) begin
            if (ld) begin m_div = div; m_phase = 0; m_pending = 1'b0; end
        end else begin
            m_phase = (m_phase + 1) % m_div;
            if (m_phase == 0) begin
                m_pulse  = 1'b1;
                m_square = ~m_square;
                if (ld) begin m_div = div; m_pending = 1'b0; end
                else if (m_pending) begin m_div = m_pend; m_pending = 1'b0; end
            end else if (ld) begin
                m_pend = div; m_pending = 1'b1;
            end
        end
    endtask

    // Drive one cycle, advance the model, then compare all outputs after the edge.
    task automatic step(input bit rst, input bit en, input bit ld, input int div);
        irst  = rst;
        iEn   = en;
        iLoad = ld;
        iDiv  = WIDTH'(div);
        @(posedge iClk);
        model_edge(rst, en, ld, div);
        #1;
        check("count",   32'(oCount),   32'(m_phase));
        check("pulse",   32'(oPulse),   32'(m_pulse));
        check("pending", 32'(oPending), 32'(m_pending));
`ifdef SQUARE_OUT_EN
        check("square",  32'(oSquare),  32'(m_square));
`endif
    endtask

    initial begin
        int en_r;
        int ld_r;
        int dv_r;
        int rs_r;
        irst = 1'b1; iEn = 1'b0; iLoad = 1'b0; iDiv = '0;
        m_div = 0; m_pend = 0; m_phase = 0;
        m_pending = 1'b0; m_pulse = 1'b0; m_square = 1'b0;

        // Reset state.
        step(1, 0, 0, 0);
        check("reset_count", 32'(oCount), 32'd0);
        check("reset_pulse", 32'(oPulse), 32'd0);

        // Free run with N=5: pulses on edges 5,10,15,20; count 1,2,3,4,0.
        for (int i = 1; i <= 20; i++) begin
            step(0, 1, 0, 0);
            check("run5_pulse", 32'(oPulse), 32'((i % 5) == 0));
            check("run5_count", 32'(oCount), 32'(i % 5));
        end

        // Mid-period load of 3 at count 1: pending until the 4->0 edge.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 3);
        check("pend_set", 32'(oPending), 32'd1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("pend_hold", 32'(oPending), 32'd1);
        step(0, 1, 0, 0);
        check("pend_apply_pulse", 32'(oPulse), 32'd1);
        check("pend_clear", 32'(oPending), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            step(0, 1, 0, 0);
            check("run3_pulse", 32'(oPulse), 32'((i % 3) == 0));
        end

        // Load 2 exactly on the terminal edge: bypass, never pending.
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 2);
        check("bypass_pulse", 32'(oPulse), 32'd1);
        check("bypass_pend", 32'(oPending), 32'd0);
        step(0, 1, 0, 0);
        check("bypass_mid", 32'(oPulse), 32'd0);
        step(0, 1, 0, 0);
        check("bypass_next", 32'(oPulse), 32'd1);

        // Pause at count 3 for 10 cycles, then resume.
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            check("pause_count", 32'(oCount), 32'd3);
            check("pause_pulse", 32'(oPulse), 32'd0);
        end
        step(0, 1, 0, 0);
        check("resume_1", 32'(oPulse), 32'd0);
        step(0, 1, 0, 0);
        check("resume_2", 32'(oPulse), 32'd1);

        // Divisor 0 stops; divisor 1 pulses every enabled cycle.
        step(0, 0, 1, 0);
        check("stop_count", 32'(oCount), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0);
            check("stop_pulse", 32'(oPulse), 32'd0);
        end
        step(0, 1, 1, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0);
            check("div1_pulse", 32'(oPulse), 32'd1);
        end

`ifdef SQUARE_OUT_EN
        // N=4 square wave, then reset mid-period.
        step(1, 0, 0, 0);
        step(0, 0, 1, 4);
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 0, 0);
            check("sq4", 32'(oSquare), 32'(((i / 4) % 2) == 1));
        end
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("sq_rst", 32'(oSquare), 32'd0);
        check("sq_rst_count", 32'(oCount), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 0, 0);
            check("sq_rst_div5", 32'(oPulse), 32'(i == 5));
        end
`endif

        // Reset while pending discards the parked divisor.
        step(1, 0, 0, 0);
        step(0, 1, 1, 2);
        step(1, 1, 0, 0);
        check("rst_pend", 32'(oPending), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 0, 0);
            check("rst_pend_div5", 32'(oPulse), 32'(i == 5));
        end

        // Randomized run against the model.
        for (int i = 0; i < 800; i++) begin
            en_r = (($urandom_range(0, 3)) != 0) ? 1 : 0;
            ld_r = (($urandom_range(0, 9)) == 0) ? 1 : 0;
            dv_r = $urandom_range(0, 9);
            rs_r = (($urandom_range(0, 99)) == 0) ? 1 : 0;
            step(bit'(rs_r), bit'(en_r), bit'(ld_r), dv_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_divider.md
PULSE_DIVIDER -- requirements
Module: pulse_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 26, counter and divisor width in bits.
REQ-002 SHALL have parameter DIV_RESET, default 50_000_000, active divisor after reset; must fit in WIDTH bits.
REQ-003 SHALL have port iClk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port irst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port iEn, input, 1, count enable; low pauses the counter.
REQ-006 SHALL have port iLoad, input, 1, one-cycle strobe capturing iDiv as the new divisor.
REQ-007 SHALL have port iDiv, input, WIDTH, requested divisor N (pulse period in enabled cycles).
REQ-008 SHALL have port oPulse, output, 1, registered one-cycle tick at each terminal count.
REQ-009 SHALL have port oPending, output, 1, high while a loaded divisor awaits application.
REQ-010 SHALL have port oCount, output, WIDTH, current counter value.

Function
REQ-011 SHALL hold active divisor rDiv, pending divisor rPend and counter rCnt, all WIDTH bits, unsigned; increments wrap modulo 2^WIDTH.
REQ-012 Enabled edge (iEn=1, rDiv!=0): if rCnt==rDiv-1 then rCnt<=0, oPulse<=1 (terminal count); else rCnt<=rCnt+1, oPulse<=0.
REQ-013 First oPulse after reset/reload SHALL be registered on the Nth enabled edge; thereafter exactly one pulse per N enabled edges; N=1 gives oPulse continuously high.
REQ-014 iEn=0 SHALL hold rCnt unchanged and drive oPulse<=0; counting resumes from the held value.
REQ-015 rDiv==0 SHALL force rCnt<=0 and oPulse<=0 regardless of iEn (divider stopped).
REQ-016 iLoad=1 on a non-terminal enabled edge SHALL set rPend<=iDiv, oPending<=1; rDiv unchanged.
REQ-017 At a terminal-count edge with oPending=1 and iLoad=0, SHALL set rDiv<=rPend, oPending<=0; that edge's pulse still issues.
REQ-018 iLoad=1 on a terminal-count edge SHALL bypass: rDiv<=iDiv, oPending<=0; any older pending value discarded.
REQ-019 iLoad=1 while iEn=0 or rDiv==0 SHALL apply immediately: rDiv<=iDiv, rCnt<=0, oPending<=0.
REQ-020 Repeated iLoad while pending SHALL overwrite rPend; last value wins.
REQ-021 A pending divisor SHALL not be applied on a disabled edge without iLoad; it waits for a terminal count or a further iLoad.
REQ-022 oCount SHALL equal rCnt; oPulse and oPending SHALL be driven directly from registers.

Reset
REQ-023 irst=1 at an edge SHALL set rCnt=0, rDiv=DIV_RESET, rPend=0, oPulse=0, oPending=0 (and oSquare=0 if present), overriding all other inputs.
REQ-024 Reset asserted mid-period or while pending SHALL discard the partial count and pending divisor; first pulse after release on the DIV_RESET-th enabled edge.

Configuration
REQ-025 Macro SQUARE_OUT_EN defined: SHALL add output oSquare, 1 bit, registered, toggling on every terminal-count edge (period 2N enabled cycles, 50% duty), held while paused, 0 in reset, 0 forced while rDiv==0.
REQ-026 Macro SQUARE_OUT_EN undefined: oSquare port and its register SHALL not exist; all other behaviour identical.

Verification (WIDTH=8, DIV_RESET=5)
REQ-027 Reset, then iEn=1 held 20 cycles -> oPulse high on enabled edges 5,10,15,20 only; oCount sequence 1,2,3,4,0 repeating.
REQ-028 iEn=1, iLoad with iDiv=3 when oCount=1 -> oPending=1 until edge with oCount 4->0 (pulse issued), then pulses every 3 edges, oPending=0.
REQ-029 iLoad iDiv=2 exactly on terminal-count edge of N=5 -> next pulse 2 edges later, oPending never asserts.
REQ-030 iEn=0 at oCount=3 for 10 cycles, then iEn=1 -> oCount stays 3, no pulse while paused, next pulse 2 enabled edges after resume.
REQ-031 iEn=0, iLoad iDiv=0 -> oCount=0, no pulses with iEn=1; then iLoad iDiv=1 -> oPulse high every enabled cycle.
REQ-032 With SQUARE_OUT_EN, N=4, iEn=1 -> oSquare toggles every 4 edges (period 8); irst pulse mid-period -> oSquare=0, oCount=0, rDiv back to 5.
